// File: rtl/dsp_stream_pkg.sv
// Shared definitions for the streaming rate-change blocks (interpolator, decimator).
package dsp_stream_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } stream_state_e;

  // Counter width for a modulo-n counter; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/interpolator_if.sv
// Valid/ready sample stream. The master drives data/valid, and the slave drives ready.
interface interpolator_if #(
  parameter int DATA_BW = 8
) ();
  logic [DATA_BW-1:0] data;
  logic               valid;
  logic               ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/interpolator_phase_counter.sv
// Modulo-N phase counter with a clear input, an advance input and a last-phase flag.
module phase_counter
  import dsp_stream_pkg::*;
#(
  parameter int N = 4,
  parameter int W = clog2_min1(N)
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         clr_i,
  input  logic         adv_i,
  output logic [W-1:0] cnt_o,
  output logic         last_o
);
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign last_o = (cnt_q == LAST);
  assign cnt_o  = cnt_q;

  // Wrap at N-1 so that factors that are not powers of two behave correctly.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (adv_i) cnt_d = last_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
endmodule

// File: rtl/interpolator.sv
// Streaming upsampler: each accepted sample becomes INTERP_FACTOR output samples,
// which are either zero-stuffed or sample-and-hold.
module interpolator
  import dsp_stream_pkg::*;
#(
  parameter int DATA_BW       = 8,
  parameter int INTERP_FACTOR = 250,
  parameter bit ZERO_STUFF    = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  interpolator_if.slave    in_if,
  interpolator_if.master   out_if
);
  localparam int COUNTER_BW = clog2_min1(INTERP_FACTOR);

  if (INTERP_FACTOR < 2) begin : g_bad_factor
    $error("interpolator: INTERP_FACTOR must be >= 2");
  end

  stream_state_e         state_q, state_d;
  logic [DATA_BW-1:0]    hold_q, hold_d;
  logic [DATA_BW-1:0]    data_c;
  logic [COUNTER_BW-1:0] phase;
  logic                  last, valid, ready, accept, transfer, clr;

  assign valid    = (state_q == ST_EMIT);
  assign transfer = valid & out_if.ready;
  // ready_i feeds ready_o combinationally, so a new sample can follow the last phase with no bubble.
  assign ready    = en_i & ((state_q == ST_IDLE) | (valid & last & out_if.ready));
  assign accept   = in_if.valid & ready;
  assign clr      = ~en_i | (state_q == ST_IDLE);

  phase_counter #(
    .N (INTERP_FACTOR),
    .W (COUNTER_BW)
  ) u_phase (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (clr),
    .adv_i   (transfer),
    .cnt_o   (phase),
    .last_o  (last)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (accept) hold_d = in_if.data;
    if (!en_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) state_d = ST_EMIT;
        ST_EMIT: if (transfer && last && !accept) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    data_c = '0;
    if (valid) data_c = (ZERO_STUFF && (phase != '0)) ? '0 : hold_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  assign in_if.ready  = ready;
  assign out_if.valid = valid;
  assign out_if.data  = data_c;
endmodule

// File: tb/tb_interpolator.sv
// Scoreboard bench: three interpolators (4/zero-stuff, 4/hold, 3/hold) driven from shared stimulus.
module tb_interpolator;
  localparam int NDUT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en, valid_s, ready_s;
  logic [7:0] data_s;

  logic [NDUT-1:0] vo, ro;
  logic [7:0]      dout [NDUT];

  logic [7:0] exp_q [NDUT][$];
  bit         acc_pend [NDUT];
  logic [7:0] acc_data [NDUT];
  int         acc_cnt  [NDUT];
  int         drop_cnt [NDUT];
  int         xfer_cnt [NDUT];
  int         pass_cnt  = 0;
  int         total_cnt = 0;
  bit         done = 1'b0;

  function automatic int fac(input int i);
    return (i == 2) ? 3 : 4;
  endfunction

  function automatic bit zs(input int i);
    return (i == 0);
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int F  = (g == 2) ? 3 : 4;
    localparam bit ZS = (g == 0);
    interpolator_if #(.DATA_BW(8)) in_if ();
    interpolator_if #(.DATA_BW(8)) out_if ();
    assign in_if.data   = data_s;
    assign in_if.valid  = valid_s;
    assign out_if.ready = ready_s;
    assign vo[g]   = out_if.valid;
    assign ro[g]   = in_if.ready;
    assign dout[g] = out_if.data;

    interpolator #(
      .DATA_BW       (8),
      .INTERP_FACTOR (F),
      .ZERO_STUFF    (ZS)
    ) u_dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .en_i    (en),
      .in_if   (in_if),
      .out_if  (out_if)
    );
  end

  task automatic flush_model();
    for (int i = 0; i < NDUT; i++) begin
      drop_cnt[i] += exp_q[i].size();
      exp_q[i].delete();
    end
  endtask

  // One clock of stimulus. The reference burst is queued on the edge that takes the sample.
  task automatic cycle(input bit v, input logic [7:0] d, input bit r, input bit e, input bit rs);
    @(posedge clk);
    if (rst_n && !en) flush_model();
    for (int i = 0; i < NDUT; i++) begin
      if (acc_pend[i]) begin
        acc_cnt[i]++;
        for (int k = 0; k < fac(i); k++)
          exp_q[i].push_back((k == 0 || !zs(i)) ? acc_data[i] : 8'h00);
      end
      acc_pend[i] = 1'b0;
    end
    #1;
    valid_s = v;
    data_s  = d;
    ready_s = r;
    en      = e;
    if (!rs) flush_model();
    rst_n = rs;
    #3;
    for (int i = 0; i < NDUT; i++) begin
      acc_pend[i] = rst_n && en && valid_s && ro[i];
      acc_data[i] = data_s;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; valid_s = 1'b0; ready_s = 1'b1; data_s = 8'h00;
    for (int i = 0; i < NDUT; i++) begin
      acc_pend[i] = 1'b0; acc_data[i] = 8'h00;
      acc_cnt[i] = 0; drop_cnt[i] = 0;
    end
    for (int k = 0; k < 3; k++) cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    idle(2);
    // Single sample
    cycle(1'b1, 8'h5A, 1'b1, 1'b1, 1'b1);
    idle(6);
    // Back-to-back samples with valid held high
    for (int k = 0; k < 12; k++) cycle(1'b1, 8'h11 * (8'(k / 4) + 8'd1), 1'b1, 1'b1, 1'b1);
    idle(6);
    // Backpressure in the middle of a burst
    cycle(1'b1, 8'h7F, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    idle(6);
    // Enable dropped mid-burst
    cycle(1'b1, 8'hC3, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 8'h01, 1'b1, 1'b1, 1'b1);
    idle(6);
    // Asynchronous reset between clock edges
    cycle(1'b1, 8'hA5, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 8'h3C, 1'b1, 1'b1, 1'b1);
    idle(6);
    // Random traffic
    for (int k = 0; k < 800; k++)
      cycle(($urandom_range(0, 9) < 7), 8'($urandom), ($urandom_range(0, 9) < 8),
            ($urandom_range(0, 39) != 0), ($urandom_range(0, 199) != 0));
    idle(12);
    done = 1'b1;
  end

  task automatic chk(input string name, input int act, input int req);
    total_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
  endtask

  // The monitor compares on the falling edge, after that cycle's inputs have settled.
  initial begin
    for (int i = 0; i < NDUT; i++) xfer_cnt[i] = 0;
    while (!done) begin
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) begin
        chk($sformatf("dut%0d valid_o", i), int'(vo[i]), int'(exp_q[i].size() != 0));
        chk($sformatf("dut%0d ready_o", i), int'(ro[i]),
            int'(en && (exp_q[i].size() == 0 || (exp_q[i].size() == 1 && ready_s))));
        if (exp_q[i].size() != 0) begin
          chk($sformatf("dut%0d data_o", i), int'(dout[i]), int'(exp_q[i][0]));
          if (vo[i] && ready_s) begin
            void'(exp_q[i].pop_front());
            xfer_cnt[i]++;
          end
        end else begin
          chk($sformatf("dut%0d idle data_o", i), int'(dout[i]), 0);
        end
      end
    end
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("dut%0d drained", i), exp_q[i].size(), 0);
      chk($sformatf("dut%0d outputs per input", i), xfer_cnt[i] + drop_cnt[i], fac(i) * acc_cnt[i]);
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
